// File: rtl/alu_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_pkg
// Brief    : Shared types, widths and ALU opcodes for alu_request_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

  localparam int ALU_W  = 8;
  localparam int SEL_W  = 4;
  localparam int FLAG_W = 4;

  localparam logic [SEL_W-1:0] OP_ADD = 4'd0;
  localparam logic [SEL_W-1:0] OP_SUB = 4'd1;
  localparam logic [SEL_W-1:0] OP_MUL = 4'd2;
  localparam logic [SEL_W-1:0] OP_DIV = 4'd3;
  localparam logic [SEL_W-1:0] OP_MOD = 4'd4;
  localparam logic [SEL_W-1:0] OP_AND = 4'd5;
  localparam logic [SEL_W-1:0] OP_OR  = 4'd6;
  localparam logic [SEL_W-1:0] OP_XOR = 4'd7;
  localparam logic [SEL_W-1:0] OP_NOT = 4'd8;
  localparam logic [SEL_W-1:0] OP_SHL = 4'd9;
  localparam logic [SEL_W-1:0] OP_SHR = 4'd10;
  localparam logic [SEL_W-1:0] OP_EQ  = 4'd11;
  localparam logic [SEL_W-1:0] OP_GT  = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_request_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_request_arbiter_if
// Brief    : Request and response handshake bundle between requesters and
//            the ALU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_request_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4
) ();

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        ReqValid;
  logic [NREQ*ALU_W-1:0]  ReqA;
  logic [NREQ*ALU_W-1:0]  ReqB;
  logic [NREQ*SEL_W-1:0]  ReqSel;
  logic [NREQ-1:0]        ReqReady;

  logic                   RspValid;
  logic [IDW-1:0]         RspId;
  logic [ALU_W-1:0]       RspData;
  logic [FLAG_W-1:0]      RspFlag;
  logic                   RspReady;

  modport master (
    output ReqValid, ReqA, ReqB, ReqSel, RspReady,
    input  ReqReady, RspValid, RspId, RspData, RspFlag
  );

  modport slave (
    input  ReqValid, ReqA, ReqB, ReqSel, RspReady,
    output ReqReady, RspValid, RspId, RspData, RspFlag
  );

endinterface
`default_nettype wire

// File: rtl/alu_request_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational rotating-priority picker; the search starts at ptr
//            and wraps modulo NREQ. Returns one-hot grant and its index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] w_pos;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    w_pos = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = wrap_add(ptr, k);
      if (!any && req[w_pos]) begin
        any        = 1'b1;
        gnt[w_pos] = 1'b1;
        idx        = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_request_arbiter
// Brief    : Shares one combinational ALU among NREQ requesters and returns
//            tagged results on a valid/ready channel.
//            Define ARB_FIXED_PRIO_EN for lowest-index-wins priority instead
//            of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module alu_request_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  alu_request_arbiter_if.slave bus,
  output logic [ALU_W-1:0]     AluA,
  output logic [ALU_W-1:0]     AluB,
  output logic [SEL_W-1:0]     AluSel,
  input  logic [ALU_W-1:0]     AluOut,
  input  logic [FLAG_W-1:0]    AluFlag,
  output logic                 Busy
);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;

  logic [NREQ-1:0]    w_gnt;
  logic [IDW-1:0]     w_idx;
  logic [IDW-1:0]     w_ptr;
  logic               w_any;
  logic               w_grant_en;

  logic [ALU_W-1:0]   w_a   [NREQ];
  logic [ALU_W-1:0]   w_b   [NREQ];
  logic [SEL_W-1:0]   w_sel [NREQ];

  logic [ALU_W-1:0]   r_alu_a;
  logic [ALU_W-1:0]   r_alu_b;
  logic [SEL_W-1:0]   r_alu_sel;
  logic [IDW-1:0]     r_rsp_id;
  logic [ALU_W-1:0]   r_rsp_data;
  logic [FLAG_W-1:0]  r_rsp_flag;
  logic               r_rsp_valid;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_a[i]   = bus.ReqA[ALU_W*i +: ALU_W];
    assign w_b[i]   = bus.ReqB[ALU_W*i +: ALU_W];
    assign w_sel[i] = bus.ReqSel[SEL_W*i +: SEL_W];
  end

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req (bus.ReqValid),
    .ptr (w_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

`ifdef ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IDW-1:0] r_ptr;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ptr <= '0;
    end else if (w_grant_en) begin
      r_ptr <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`endif

  // Reset also masks the accept strobe so no requester sees a phantom grant.
  assign w_grant_en   = (r_state == IDLE) && w_any && !Rst;
  assign bus.ReqReady = w_grant_en ? w_gnt : '0;

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_grant_en) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = RESP;
      RESP:    if (bus.RspReady) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_flag  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_grant_en) begin
        r_alu_a   <= w_a[w_idx];
        r_alu_b   <= w_b[w_idx];
        r_alu_sel <= w_sel[w_idx];
        r_rsp_id  <= w_idx;
      end
      if (r_state == ISSUE) begin
        r_rsp_data  <= AluOut;
        r_rsp_flag  <= AluFlag;
        r_rsp_valid <= 1'b1;
      end
      if (r_state == RESP && bus.RspReady) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign AluA         = r_alu_a;
  assign AluB         = r_alu_b;
  assign AluSel       = r_alu_sel;
  assign bus.RspValid = r_rsp_valid;
  assign bus.RspId    = r_rsp_id;
  assign bus.RspData  = r_rsp_data;
  assign bus.RspFlag  = r_rsp_flag;
  assign Busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_request_arbiter
// Brief    : Directed self-checking bench with a behavioural ALU and a
//            response scoreboard for alu_request_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_request_arbiter;
  import alu_arb_pkg::*;

  localparam int NREQ = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic [3:0] flag;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [7:0]  AluA, AluB, AluOut;
  logic [3:0]  AluSel, AluFlag;
  logic        Busy;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  int   grant_log[$];
  logic [11:0] mon_r;
  exp_t        mon_e;

  alu_request_arbiter_if #(.NREQ(NREQ)) bus ();

  alu_request_arbiter #(.NREQ(NREQ)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .bus     (bus),
    .AluA    (AluA),
    .AluB    (AluB),
    .AluSel  (AluSel),
    .AluOut  (AluOut),
    .AluFlag (AluFlag),
    .Busy    (Busy)
  );

  always #5 Clk = ~Clk;

  // Behavioural ALU: flags {err/borrow, mul-ovf, carry, zero}.
  function automatic logic [11:0] alu_model(input logic [3:0] sel, input logic [7:0] a,
                                            input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  o;
    logic [3:0]  f;
    s = '0; p = '0; o = '0; f = '0;
    if (sel > OP_GT) return 12'h000;
    case (sel)
      OP_ADD:  begin s = {1'b0, a} + {1'b0, b}; o = s[7:0]; f[1] = s[8]; end
      OP_SUB:  begin s = {1'b0, a} - {1'b0, b}; o = s[7:0]; f[3] = s[8]; end
      OP_MUL:  begin p = a * b; o = p[7:0]; f[2] = |p[15:8]; end
      OP_DIV:  begin if (b == 8'd0) f[3] = 1'b1; else o = a / b; end
      default: o = a ^ b;
    endcase
    f[0] = (o == 8'd0);
    return {f, o};
  endfunction

  assign {AluFlag, AluOut} = alu_model(AluSel, AluA, AluB);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic samp();
    @(negedge Clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 20) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, Busy}, 32'd0);
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel);
    bus.ReqA[8*i +: 8]   = a;
    bus.ReqB[8*i +: 8]   = b;
    bus.ReqSel[4*i +: 4] = sel;
  endtask

  // Scoreboard: predict at grant, compare at the accepting handshake.
  always @(negedge Clk) begin
    if (Rst) begin
      sb.delete();
    end else begin
      check("onehot", ($countones(bus.ReqReady) <= 1) ? 32'd1 : 32'd0, 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ReqReady[i]) begin
          grant_log.push_back(i);
          mon_r = alu_model(bus.ReqSel[4*i +: 4], bus.ReqA[8*i +: 8], bus.ReqB[8*i +: 8]);
          sb.push_back('{id: 2'(i), data: mon_r[7:0], flag: mon_r[11:8]});
        end
      end
      if (bus.RspValid && bus.RspReady) begin
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL sb_empty observed=0 expected>0");
        end
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("sb_id",   32'(bus.RspId),   32'(mon_e.id));
          check("sb_data", 32'(bus.RspData), 32'(mon_e.data));
          check("sb_flag", 32'(bus.RspFlag), 32'(mon_e.flag));
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Rst          = 1'b1;
    bus.ReqValid = 4'hF;
    bus.ReqA     = '0;
    bus.ReqB     = '0;
    bus.ReqSel   = '0;
    bus.RspReady = 1'b0;
    repeat (3) tick();
    samp();
    check("rst_reqready", 32'(bus.ReqReady), 32'd0);
    check("rst_rspvalid", 32'(bus.RspValid), 32'd0);
    check("rst_busy",     32'(Busy),         32'd0);
    check("rst_alua",     32'(AluA),         32'd0);
    check("rst_alusel",   32'(AluSel),       32'd0);
    check("rst_rspid",    32'(bus.RspId),    32'd0);
    check("rst_rspdata",  32'(bus.RspData),  32'd0);

    // Single request on req0: 200+100 wraps with carry.
    tick();
    Rst = 1'b0;
    set_req(0, 8'd200, 8'd100, OP_ADD);
    bus.ReqValid = 4'b0001;
    samp();
    check("t1_grant", 32'(bus.ReqReady), 32'b0001);
    tick();
    bus.ReqValid = 4'b0000;
    samp();
    check("t1_issue_valid", 32'(bus.RspValid), 32'd0);
    check("t1_issue_busy",  32'(Busy),         32'd1);
    check("t1_alua",        32'(AluA),         32'd200);
    check("t1_alub",        32'(AluB),         32'd100);
    check("t1_alusel",      32'(AluSel),       32'd0);
    tick();
    bus.RspReady = 1'b1;
    samp();
    check("t1_rspvalid", 32'(bus.RspValid), 32'd1);
    check("t1_rspdata",  32'(bus.RspData),  32'd44);
    check("t1_rspflag",  32'(bus.RspFlag),  32'b0010);
    check("t1_rspid",    32'(bus.RspId),    32'd0);
    tick();
    bus.RspReady = 1'b0;
    samp();
    check("t1_done_valid", 32'(bus.RspValid), 32'd0);
    check("t1_done_busy",  32'(Busy),         32'd0);
    check("t1_alua_hold",  32'(AluA),         32'd200);

    // Subtract with borrow on req1.
    tick();
    set_req(1, 8'd5, 8'd9, OP_SUB);
    bus.ReqValid = 4'b0010;
    samp();
    check("t2_grant", 32'(bus.ReqReady), 32'b0010);
    tick();
    bus.ReqValid = 4'b0000;
    tick();
    bus.RspReady = 1'b1;
    samp();
    check("t2_rspdata", 32'(bus.RspData), 32'd252);
    check("t2_rspflag", 32'(bus.RspFlag), 32'b1000);
    check("t2_rspid",   32'(bus.RspId),   32'd1);
    tick();
    bus.RspReady = 1'b0;

    // Divide by zero on req2 with a stalled consumer; req3 waits behind it.
    tick();
    set_req(2, 8'd7, 8'd0, OP_DIV);
    set_req(3, 8'd3, 8'd4, OP_MUL);
    bus.ReqValid = 4'b1100;
    samp();
    check("t3_grant", 32'(bus.ReqReady), 32'b0100);
    tick();
    bus.ReqValid = 4'b1000;
    samp();
    check("t3_issue_nogrant", 32'(bus.ReqReady), 32'd0);
    tick();
    repeat (5) begin
      samp();
      check("t3_stall_valid",   32'(bus.RspValid), 32'd1);
      check("t3_stall_data",    32'(bus.RspData),  32'd0);
      check("t3_stall_flag",    32'(bus.RspFlag),  32'b1001);
      check("t3_stall_id",      32'(bus.RspId),    32'd2);
      check("t3_stall_nogrant", 32'(bus.ReqReady), 32'd0);
      tick();
    end
    bus.RspReady = 1'b1;
    samp();
    check("t3_pre_accept_valid", 32'(bus.RspValid), 32'd1);
    tick();
    samp();
    check("t3_next_grant", 32'(bus.ReqReady), 32'b1000);
    tick();
    bus.ReqValid = 4'b0000;
    wait_idle();

    // All four requesting with the consumer always ready.
    tick();
    set_req(0, 8'd1,   8'd2,   OP_ADD);
    set_req(1, 8'd9,   8'd3,   OP_SUB);
    set_req(2, 8'h10,  8'h10,  OP_MUL);
    set_req(3, 8'd5,   8'd6,   4'd13);
    grant_log.delete();
    bus.ReqValid = 4'b1111;
    bus.RspReady = 1'b1;
    n = 0;
    samp();
    #1;
    while (grant_log.size() < 5 && n < 40) begin
      tick();
      samp();
      #1;
      n++;
    end
    tick();
    bus.ReqValid = 4'b0000;
    wait_idle();
    check("rr_count", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < grant_log.size() && i < 5; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      check("rr_order", 32'(grant_log[i]), 32'd0);
`else
      check("rr_order", 32'(grant_log[i]), 32'(i % 4));
`endif
    end

    // Reset during ISSUE drops the response and rewinds the pointer.
    tick();
    set_req(1, 8'd10, 8'd20, OP_ADD);
    bus.ReqValid = 4'b0010;
    bus.RspReady = 1'b0;
    samp();
    check("t5_grant", 32'(bus.ReqReady), 32'b0010);
    tick();
    bus.ReqValid = 4'b0000;
    Rst = 1'b1;
    samp();
    check("t5_issue_busy", 32'(Busy), 32'd1);
    tick();
    bus.ReqValid = 4'b1001;
    samp();
    check("t5_rst_valid",    32'(bus.RspValid), 32'd0);
    check("t5_rst_busy",     32'(Busy),         32'd0);
    check("t5_rst_reqready", 32'(bus.ReqReady), 32'd0);
    tick();
    Rst = 1'b0;
    samp();
    check("t5_post_rst_grant", 32'(bus.ReqReady), 32'b0001);
    tick();
    bus.ReqValid = 4'b0000;
    bus.RspReady = 1'b1;
    wait_idle();

    // req1 and req3 both held.
    tick();
    grant_log.delete();
    bus.ReqValid = 4'b1010;
    n = 0;
    samp();
    #1;
    while (grant_log.size() < 4 && n < 40) begin
      tick();
      samp();
      #1;
      n++;
    end
    tick();
    bus.ReqValid = 4'b0000;
    wait_idle();
    check("pair_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      check("pair_order", 32'(grant_log[i]), 32'd1);
`else
      check("pair_order", 32'(grant_log[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
`endif
    end

    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_request_arbiter.md
Name: alu_request_arbiter

Overview:
Shares the single combinational 8-bit ALU between NREQ independent requesters, such as the host command path and internal self-test or sequencer agents. It selects one pending request, drives registered operands and opcode into the ALU, and captures result and flags one cycle later. It then returns them on a valid/ready response channel tagged with the requester index. It sits between the requesters and the ALU instance, replacing the direct regA/regB/regSel register drive.

Parameters:
NREQ, 4, number of requesters (2..8).
IDW, $clog2(NREQ), requester-index width (derived; not overridden).

Ports:
Clk  in  1  system clock.
Rst  in  1  synchronous active-high reset.
ReqValid  in  NREQ  per-requester request valid.
ReqA  in  NREQ*8  operand A, requester i at [8i+7:8i].
ReqB  in  NREQ*8  operand B, same packing.
ReqSel  in  NREQ*4  ALU opcode, requester i at [4i+3:4i].
ReqReady  out  NREQ  one-hot accept strobe.
AluA  out  8  registered operand A to ALU.
AluB  out  8  registered operand B to ALU.
AluSel  out  4  registered opcode to ALU.
AluOut  in  8  ALU result.
AluFlag  in  4  ALU flags {err/borrow, mul-ovf, carry, zero}.
RspValid  out  1  response valid.
RspId  out  IDW  index of the requester that owns the response.
RspData  out  8  captured ALU result.
RspFlag  out  4  captured ALU flags.
RspReady  in  1  response consumer ready.
Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, Rst sampled at posedge Clk): state=IDLE; outputs AluA/AluB/AluSel/RspData/RspFlag/RspId=0; RspValid=0; ReqReady=0; Busy=0; round-robin pointer=0.
- Reset asserted mid-operation aborts the operation; any pending response is dropped and never re-presented.
- FSM: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
- IDLE: if any ReqValid is set, the winner g is picked.
  - ReqReady[g]=1 combinationally in this cycle only; all other ReqReady bits are 0.
  - At the next edge, ReqA/ReqB/ReqSel of g load into AluA/AluB/AluSel, g is stored as RspId, and state goes to ISSUE.
  - If no ReqValid is set, state stays IDLE and ReqReady=0.
- ISSUE: one settle cycle for the combinational ALU. At the next edge, AluOut->RspData, AluFlag->RspFlag, RspValid<=1, state goes to CAPTURE->RESP (CAPTURE is the edge action; the FSM enters RESP directly).
- RESP: RspValid, RspId, RspData and RspFlag hold stable until RspReady=1 is sampled at an edge.
  - At that edge RspValid<=0 and state goes to IDLE.
  - RspReady is ignored when RspValid=0.
- Latency: grant cycle T; RspValid=1 from cycle T+2. Minimum issue interval is 3 cycles (grant, issue, response-accept-with-ready).
- AluA/AluB/AluSel hold their last value after the operation; they change only on a grant.
- Round-robin: search starts at ptr and runs ptr, ptr+1, ..., wrapping modulo NREQ. After granting g, ptr<=(g+1) mod NREQ, wrapping to 0 when g=NREQ-1.
- Simultaneous requests: exactly one grant per grant cycle. Losers keep ReqValid high; no request is lost.
- A requester must hold ReqValid and its operands stable until ReqReady is seen. Deasserting ReqValid before grant withdraws the request.
- Opcodes 13..15 pass through unchecked; the ALU returns Out=0 and Flag=0000.

Optional Feature:
ARB_FIXED_PRIO_EN:
- Defined: fixed priority; the lowest-index valid requester always wins, and the pointer is not implemented.
- Undefined: round-robin as specified above.

Decomposition:
- Package alu_arb_pkg holds:
  - state enum arb_state_t {IDLE, ISSUE, RESP};
  - constants ALU_W=8, SEL_W=4, FLAG_W=4;
  - opcode localparams OP_ADD=0 .. OP_GT=12.
- One natural sub-module: rr_picker, a combinational request-vector plus pointer to one-hot grant and index, parameterised by NREQ.

Test Plan:
- Single request: req0 A=200, B=100, Sel=0 -> ReqReady[0] at T; RspValid at T+2 with RspData=44, RspFlag=0010, RspId=0.
- Round-robin fairness: all 4 ReqValid held high, RspReady tied 1 -> grant order 0,1,2,3,0; no ReqReady ever has more than one bit set.
- Divide by zero with stall: req2 A=7, B=0, Sel=3, RspReady=0 for 5 cycles -> RspData=0, RspFlag=1001, RspId=2 held stable for 5 cycles; no new grant until the accept edge.
- Subtract borrow: req1 A=5, B=9, Sel=1 -> RspData=252, RspFlag=1000.
- Reset mid-operation: Rst=1 during ISSUE -> next cycle RspValid=0, Busy=0; the following grant goes to req0.
- ARB_FIXED_PRIO_EN defined, req1 and req3 held high -> req1 granted on every grant, req3 starved.
